bool_func_engine: RTL and testbench

//  Runtime-programmable bank of M boolean functions of N inputs, each held as a 2^N-bit truth table.

---
 rtl/bool_func_pkg.sv | 36 +++
 rtl/bool_func_cfg_loader.sv | 75 +++++++
 rtl/bool_func_engine.sv | 98 +++++++++
 tb/tb_bool_func_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bool_func_pkg.sv
// Shared types, sizing helpers and standard truth tables for the boolean function engine.
// Table bit index equals the input vector value, with in_data[N-1] as the first variable.
package bool_func_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_LOAD   = 2'd1,
        CFG_COMMIT = 2'd2
    } cfg_state_e;

    // Returns clog2(v), never less than 1, so that single-entry indexes stay one bit wide.
    function automatic int clog2_1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int calc_beats(input int n, input int cfg_w);
        return (1 << n) / cfg_w;
    endfunction

    function automatic int sel_width(input int m);
        return clog2_1(m);
    endfunction

    localparam int N_DEF     = 4;
    localparam int M_DEF     = 5;
    localparam int CFG_W_DEF = 8;
    localparam int BEATS_DEF = calc_beats(N_DEF, CFG_W_DEF);
    localparam int SEL_W_DEF = sel_width(M_DEF);

    localparam logic [15:0] F_AND_OR_NOT = 16'hF222;
    localparam logic [15:0] F_NOR3       = 16'h0003;
    localparam logic [15:0] F_XOR_AND_OR = 16'h3CC0;
    localparam logic [15:0] F_NEQ3       = 16'h7EE7;
    localparam logic [15:0] F_XOR_NAND   = 16'hFCCF;

endpackage

// File: rtl/bool_func_cfg_loader.sv
// Config loader: collects a truth table in CFG_W-bit beats into a shadow register,
// then raises commit_en for exactly one cycle while cfg_ready is held low.
module bool_func_cfg_loader
    import bool_func_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int M     = 5,
    parameter  int CFG_W = 8,
    localparam int TBL_W = 1 << N,
    localparam int SEL_W = sel_width(M),
    localparam int BEATS = calc_beats(N, CFG_W),
    localparam int BCW   = clog2_1(BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [SEL_W-1:0] i_cfg_sel,
    input  logic [CFG_W-1:0] i_cfg_data,
    output logic             o_commit_en,
    output logic [SEL_W-1:0] o_commit_sel,
    output logic [TBL_W-1:0] o_commit_tbl
);

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    cfg_state_e       r_state;
    cfg_state_e       w_next;
    logic [BCW-1:0]   r_beat;
    logic [SEL_W-1:0] r_sel;
    logic [TBL_W-1:0] r_shadow;
    logic             w_acc;
    logic             w_last;

    assign o_cfg_ready = (r_state != CFG_COMMIT);
    assign w_acc       = i_cfg_valid & o_cfg_ready;
    assign w_last      = (r_beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= CFG_IDLE;
        else        r_state <= w_next;
    end

    // IDLE and LOAD share a transition: the counter is 0 in IDLE, so a
    // single-beat table goes straight to COMMIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            CFG_IDLE, CFG_LOAD: begin
                if (w_acc) w_next = w_last ? CFG_COMMIT : CFG_LOAD;
            end
            CFG_COMMIT: w_next = CFG_IDLE;
            default:    w_next = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat   <= '0;
            r_sel    <= '0;
            r_shadow <= '0;
        end else if (w_acc) begin
            if (r_state == CFG_IDLE) r_sel <= i_cfg_sel;
            for (int b = 0; b < BEATS; b++) begin
                if (r_beat == BCW'(b)) r_shadow[b*CFG_W +: CFG_W] <= i_cfg_data;
            end
            r_beat <= w_last ? '0 : r_beat + 1'b1;
        end
    end

    assign o_commit_en  = (r_state == CFG_COMMIT);
    assign o_commit_sel = r_sel;
    assign o_commit_tbl = r_shadow;

endmodule

// File: rtl/bool_func_engine.sv
// Runtime-programmable bank of M N-input boolean functions, evaluated through a
// single registered output stage with valid/ready flow control.
module bool_func_engine
    import bool_func_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int M     = 5,
    parameter  int CFG_W = 8,
    localparam int TBL_W = 1 << N,
    localparam int SEL_W = sel_width(M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_y
);

    logic                      w_commit_en;
    logic [SEL_W-1:0]          w_commit_sel;
    logic [TBL_W-1:0]          w_commit_tbl;
    logic [M-1:0][TBL_W-1:0]   r_tbl;
    logic [M-1:0]              w_hit;
    logic [M-1:0]              w_y;
    logic                      w_in_acc;
    logic                      r_cfg_done;
    logic                      r_cfg_err;
    logic                      r_out_valid;
    logic [M-1:0]              r_out_y;

    bool_func_cfg_loader #(
        .N     (N),
        .M     (M),
        .CFG_W (CFG_W)
    ) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_sel    (cfg_sel),
        .i_cfg_data   (cfg_data),
        .o_commit_en  (w_commit_en),
        .o_commit_sel (w_commit_sel),
        .o_commit_tbl (w_commit_tbl)
    );

    // An out-of-range select matches no entry, so it commits nothing and flags an error.
    for (genvar k = 0; k < M; k++) begin : g_fn
        assign w_hit[k] = w_commit_en && (w_commit_sel == SEL_W'(k));
        assign w_y[k]   = r_tbl[k][in_data];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tbl      <= '0;
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            for (int k = 0; k < M; k++) begin
                if (w_hit[k]) r_tbl[k] <= w_commit_tbl;
            end
            r_cfg_done <= w_commit_en &  (|w_hit);
            r_cfg_err  <= w_commit_en & ~(|w_hit);
        end
    end

    assign cfg_done = r_cfg_done;
    assign cfg_err  = r_cfg_err;

    // Lookup reads the live table, so a vector taken on the commit edge sees the old contents.
    assign in_ready = ~r_out_valid | out_ready;
    assign w_in_acc = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
        end else if (w_in_acc) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_y;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;

endmodule

// File: tb/tb_bool_func_engine.sv
// Directed bench for bool_func_engine: a negedge monitor keeps a truth-table model and a
// scoreboard of expected results; the main sequence runs reset, load, sweep, stall, race and bad-select.
module tb_bool_func_engine;
    import bool_func_pkg::*;

    localparam int N     = 4;
    localparam int M     = 5;
    localparam int CFG_W = 8;
    localparam int SEL_W = 3;

    logic             clk;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_sel;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_done;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     out_y;

    bool_func_engine #(.N(N), .M(M), .CFG_W(CFG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           n_done = 0;
    int           n_err  = 0;
    logic [M-1:0] sb[$];
    logic [M-1:0] got_y[$];
    int           got_cyc[$];
    logic [15:0]  m_tbl [M];
    logic [15:0]  pkg_t [M];
    int           pend_sel = 0;
    logic [15:0]  pend_tbl = '0;
    bit           exp_done = 0;
    bit           exp_err  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [M-1:0] model(input logic [N-1:0] v);
        logic [M-1:0] r;
        r = '0;
        for (int k = 0; k < M; k++) r[k] = m_tbl[k][v];
        return r;
    endfunction

    // Monitor: pops/compares results, pushes expectations, and tracks COMMIT
    // (the one cycle cfg_ready is low) to update the model after the old-table vector.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
                else                chk("out_y", 32'(out_y), 32'(sb.pop_front()));
                got_y.push_back(out_y);
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) sb.push_back(model(in_data));
            if (exp_done || cfg_done) chk("cfg_done", 32'(cfg_done), 32'(exp_done));
            if (exp_err  || cfg_err)  chk("cfg_err",  32'(cfg_err),  32'(exp_err));
            if (cfg_done) n_done++;
            if (cfg_err)  n_err++;
            exp_done = 0;
            exp_err  = 0;
            if (!cfg_ready) begin
                if (pend_sel < M) begin
                    m_tbl[pend_sel] = pend_tbl;
                    exp_done = 1;
                end else begin
                    exp_err = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cfg();
        int g;
        g = 0;
        @(negedge clk);
        while (!cfg_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Second beat carries the complement select to prove it is sampled on beat 0 only.
    task automatic load(input int sel, input logic [15:0] tbl);
        pend_sel = sel;
        pend_tbl = tbl;
        for (int b = 0; b < 2; b++) begin
            cfg_valid = 1'b1;
            cfg_sel   = (b == 0) ? SEL_W'(sel) : ~SEL_W'(sel);
            cfg_data  = tbl[b*8 +: 8];
            wait_cfg();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic eval1(input logic [N-1:0] v, output logic [M-1:0] y);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("eval_valid", 32'(out_valid), 32'd1);
        y = out_y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [M-1:0] y;
        logic [M-1:0] e;
        logic [M-1:0] hold;
        int           d0;
        int           e0;
        int           v;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int k = 0; k < M; k++) m_tbl[k] = '0;
        pkg_t[0] = F_AND_OR_NOT; pkg_t[1] = F_NOR3; pkg_t[2] = F_XOR_AND_OR;
        pkg_t[3] = F_NEQ3;       pkg_t[4] = F_XOR_NAND;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_cfg_done",  32'(cfg_done),  32'd0);
        chk("rst_cfg_err",   32'(cfg_err),   32'd0);
        chk("rst_out_y",     32'(out_y),     32'd0);
        rst_n = 1'b1;
        tick();

        // T1: live table, pending result and half a load, all wiped by reset
        load(3, 16'hFFFF);
        repeat (3) tick();
        eval1(4'hF, y);
        chk("t1_preload", 32'(y[3]), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 4'h3;
        tick();
        in_valid  = 1'b0;
        cfg_valid = 1'b1; cfg_sel = 3'd2; cfg_data = 8'hAA;
        tick();
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        for (int k = 0; k < M; k++) m_tbl[k] = '0;
        exp_done = 0; exp_err = 0;
        @(negedge clk);
        chk("t1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("t1_out_y",     32'(out_y),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        eval1(4'hF, y);
        chk("t1_tbl_clear", 32'(y), 32'd0);

        // T2: F222 into function 0
        d0 = n_done; e0 = n_err;
        load(0, 16'hF222);
        repeat (3) tick();
        chk("t2_done_cnt", 32'(n_done - d0), 32'd1);
        chk("t2_err_cnt",  32'(n_err - e0),  32'd0);
        eval1(4'b1100, y);
        chk("t2_y_1100", 32'(y[0]), 32'd1);
        eval1(4'b0010, y);
        chk("t2_y_0010", 32'(y[0]), 32'd0);

        // T3: all package tables, full back-to-back sweep
        for (int k = 0; k < M; k++) load(k, pkg_t[k]);
        repeat (3) tick();
        got_y.delete(); got_cyc.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = N'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t3_count", 32'(got_y.size()), 32'd16);
        if (got_cyc.size() == 16) chk("t3_span", 32'(got_cyc[15] - got_cyc[0]), 32'd15);
        for (int i = 0; i < 16 && i < got_y.size(); i++) begin
            for (int k = 0; k < M; k++) e[k] = pkg_t[k][i];
            chk("t3_pkg_bits", 32'(got_y[i]), 32'(e));
        end

        // T4: 3-cycle output stall with input held valid
        v = 0; in_data = '0; in_valid = 1'b1;
        repeat (3) begin
            tick();
            v++;
            in_data = N'(v);
        end
        out_ready = 1'b0;
        @(negedge clk);
        hold = out_y;
        chk("t4_in_ready_lo", 32'(in_ready), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t4_hold_y",     32'(out_y),     32'(hold));
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_in_ready",   32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            v++;
            in_data = N'(v);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t4_drained", 32'(sb.size()), 32'd0);

        // T5: vector on the COMMIT edge sees old table, next one sees new
        load(0, 16'h0000);
        repeat (3) tick();
        got_y.delete();
        pend_sel = 0; pend_tbl = 16'hFFFF;
        in_valid = 1'b1; in_data = 4'h5;
        cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_data = 8'hFF;
        tick();
        cfg_sel = 3'd7;
        tick();
        cfg_valid = 1'b0;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t5_count", 32'(got_y.size()), 32'd5);
        if (got_y.size() >= 4) begin
            chk("t5_commit_vec", 32'(got_y[2][0]), 32'd0);
            chk("t5_after_vec",  32'(got_y[3][0]), 32'd1);
        end

        // T6: out-of-range select
        d0 = n_done; e0 = n_err;
        load(7, 16'h5A5A);
        repeat (3) tick();
        chk("t6_err_cnt",  32'(n_err - e0),  32'd1);
        chk("t6_done_cnt", 32'(n_done - d0), 32'd0);
        got_y.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = N'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t6_count", 32'(got_y.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_y.size(); i++) begin
            e[0] = 1'b1;
            for (int k = 1; k < M; k++) e[k] = pkg_t[k][i];
            chk("t6_tbl_kept", 32'(got_y[i]), 32'(e));
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
